// File: rtl/cluster_to_l2_rr_arb_if.sv
// -----------------------------------------------------------------------------
// cluster_to_l2_rr_arb_if
//
// Bundle of every handshake and payload signal between the clusters, the
// cluster_to_l2_rr_arb block and the L2 cache.
//   slave  : view of the arbiter itself (takes cluster requests and L2
//            responses, drives the L2 request and the per-cluster responses).
//   master : view of the surrounding environment (the reverse directions).
// Per-cluster fields are packed vectors with cluster k in slice k.
// -----------------------------------------------------------------------------
interface cluster_to_l2_rr_arb_if #(
  parameter int NUM_CLUSTER  = 4,
  parameter int OP_BITS      = 3,
  parameter int SIZE_BITS    = 3,
  parameter int SOURCE_BITS  = 8,
  parameter int ADDRESS_BITS = 32,
  parameter int MASK_BITS    = 16,
  parameter int DATA_BITS    = 128,
  parameter int PARAM_BITS   = 3
);
  localparam int ID_BITS   = (NUM_CLUSTER > 1) ? $clog2(NUM_CLUSTER) : 0;
  localparam int SRC_OUT_W = SOURCE_BITS + ID_BITS;

  // Cluster -> arbiter requests
  logic [NUM_CLUSTER-1:0]              req_in_valid_i;
  logic [NUM_CLUSTER-1:0]              req_in_ready_o;
  logic [NUM_CLUSTER*OP_BITS-1:0]      req_in_opcode_i;
  logic [NUM_CLUSTER*SIZE_BITS-1:0]    req_in_size_i;
  logic [NUM_CLUSTER*SOURCE_BITS-1:0]  req_in_source_i;
  logic [NUM_CLUSTER*ADDRESS_BITS-1:0] req_in_address_i;
  logic [NUM_CLUSTER*MASK_BITS-1:0]    req_in_mask_i;
  logic [NUM_CLUSTER*DATA_BITS-1:0]    req_in_data_i;
  logic [NUM_CLUSTER*PARAM_BITS-1:0]   req_in_param_i;

  // Arbiter -> L2 request
  logic                    req_out_valid_o;
  logic                    req_out_ready_i;
  logic [OP_BITS-1:0]      req_out_opcode_o;
  logic [SIZE_BITS-1:0]    req_out_size_o;
  logic [SRC_OUT_W-1:0]    req_out_source_o;
  logic [ADDRESS_BITS-1:0] req_out_address_o;
  logic [MASK_BITS-1:0]    req_out_mask_o;
  logic [DATA_BITS-1:0]    req_out_data_o;
  logic [PARAM_BITS-1:0]   req_out_param_o;

  // L2 -> arbiter response
  logic                    rsp_in_valid_i;
  logic                    rsp_in_ready_o;
  logic [OP_BITS-1:0]      rsp_in_opcode_i;
  logic [SIZE_BITS-1:0]    rsp_in_size_i;
  logic [SRC_OUT_W-1:0]    rsp_in_source_i;
  logic [ADDRESS_BITS-1:0] rsp_in_address_i;
  logic [DATA_BITS-1:0]    rsp_in_data_i;
  logic [PARAM_BITS-1:0]   rsp_in_param_i;

  // Arbiter -> cluster responses
  logic [NUM_CLUSTER-1:0]              rsp_out_valid_o;
  logic [NUM_CLUSTER-1:0]              rsp_out_ready_i;
  logic [NUM_CLUSTER*OP_BITS-1:0]      rsp_out_opcode_o;
  logic [NUM_CLUSTER*SIZE_BITS-1:0]    rsp_out_size_o;
  logic [NUM_CLUSTER*SOURCE_BITS-1:0]  rsp_out_source_o;
  logic [NUM_CLUSTER*ADDRESS_BITS-1:0] rsp_out_address_o;
  logic [NUM_CLUSTER*DATA_BITS-1:0]    rsp_out_data_o;
  logic [NUM_CLUSTER*PARAM_BITS-1:0]   rsp_out_param_o;

  modport slave (
    input  req_in_valid_i, req_in_opcode_i, req_in_size_i, req_in_source_i,
           req_in_address_i, req_in_mask_i, req_in_data_i, req_in_param_i,
    output req_in_ready_o,
    output req_out_valid_o, req_out_opcode_o, req_out_size_o, req_out_source_o,
           req_out_address_o, req_out_mask_o, req_out_data_o, req_out_param_o,
    input  req_out_ready_i,
    input  rsp_in_valid_i, rsp_in_opcode_i, rsp_in_size_i, rsp_in_source_i,
           rsp_in_address_i, rsp_in_data_i, rsp_in_param_i,
    output rsp_in_ready_o,
    output rsp_out_valid_o, rsp_out_opcode_o, rsp_out_size_o, rsp_out_source_o,
           rsp_out_address_o, rsp_out_data_o, rsp_out_param_o,
    input  rsp_out_ready_i
  );

  modport master (
    output req_in_valid_i, req_in_opcode_i, req_in_size_i, req_in_source_i,
           req_in_address_i, req_in_mask_i, req_in_data_i, req_in_param_i,
    input  req_in_ready_o,
    input  req_out_valid_o, req_out_opcode_o, req_out_size_o, req_out_source_o,
           req_out_address_o, req_out_mask_o, req_out_data_o, req_out_param_o,
    output req_out_ready_i,
    output rsp_in_valid_i, rsp_in_opcode_i, rsp_in_size_i, rsp_in_source_i,
           rsp_in_address_i, rsp_in_data_i, rsp_in_param_i,
    input  rsp_in_ready_o,
    input  rsp_out_valid_o, rsp_out_opcode_o, rsp_out_size_o, rsp_out_source_o,
           rsp_out_address_o, rsp_out_data_o, rsp_out_param_o,
    output rsp_out_ready_i
  );
endinterface

// File: rtl/cluster_to_l2_rr_arb.sv
// -----------------------------------------------------------------------------
// cluster_to_l2_rr_arb
//
// N:1 request arbiter and 1:N response router between NUM_CLUSTER cluster
// memory ports and the L2 cache.
//   * Requests: one cluster is granted per cycle, its source is tagged with the
//     cluster index in the MSBs and the beat is held in a one-entry output
//     register (1 cycle latency, 1 beat/cycle under continuous ready).
//   * Responses: routed by the source MSBs into a one-entry register per
//     cluster; the tag is stripped. Targets >= NUM_CLUSTER are accepted and
//     dropped.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset; discards all held beats
//   bus  : cluster_to_l2_rr_arb_if.slave, all handshake and payload signals
//
// Configuration macro CLUSTER_L2_ARB_RR_EN:
//   defined   : round-robin grant starting at rr_ptr, searching upward with wrap
//   undefined : fixed priority, lowest valid index wins, no rr_ptr
// -----------------------------------------------------------------------------
module cluster_to_l2_rr_arb #(
  parameter int NUM_CLUSTER  = 4,
  parameter int OP_BITS      = 3,
  parameter int SIZE_BITS    = 3,
  parameter int SOURCE_BITS  = 8,
  parameter int ADDRESS_BITS = 32,
  parameter int MASK_BITS    = 16,
  parameter int DATA_BITS    = 128,
  parameter int PARAM_BITS   = 3
) (
  input logic                   clk,
  input logic                   rst,
  cluster_to_l2_rr_arb_if.slave bus
);
  localparam int ID_BITS   = (NUM_CLUSTER > 1) ? $clog2(NUM_CLUSTER) : 0;
  localparam int SRC_OUT_W = SOURCE_BITS + ID_BITS;
  // Index vectors need at least one bit even for a single cluster.
  localparam int IDX_W     = (NUM_CLUSTER > 1) ? $clog2(NUM_CLUSTER) : 1;

  typedef struct packed {
    logic [OP_BITS-1:0]      opcode;
    logic [SIZE_BITS-1:0]    size;
    logic [SRC_OUT_W-1:0]    source;
    logic [ADDRESS_BITS-1:0] address;
    logic [MASK_BITS-1:0]    mask;
    logic [DATA_BITS-1:0]    data;
    logic [PARAM_BITS-1:0]   param;
  } req_beat_t;

  typedef struct packed {
    logic [OP_BITS-1:0]      opcode;
    logic [SIZE_BITS-1:0]    size;
    logic [SOURCE_BITS-1:0]  source;
    logic [ADDRESS_BITS-1:0] address;
    logic [DATA_BITS-1:0]    data;
    logic [PARAM_BITS-1:0]   param;
  } rsp_beat_t;

  // ---------------------------------------------------------------------------
  // Request arbitration
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   stage_rdy;
  logic                   req_fire;
  logic [SOURCE_BITS-1:0] sel_source;
  logic [SRC_OUT_W-1:0]   tagged_source;
  req_beat_t              sel_beat;

  logic                   rq_full_q, rq_full_d;
  req_beat_t              rq_beat_q, rq_beat_d;

`ifdef CLUSTER_L2_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  int               cand;

  // NOTE: every combinational output gets a default at the top of the block,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    // Walk offsets from farthest to nearest so the nearest valid port above
    // rr_ptr (with wrap) is the last, winning, assignment.
    for (int off = NUM_CLUSTER - 1; off >= 0; off--) begin
      cand = (int'(rr_ptr_q) + off) % NUM_CLUSTER;
      if (bus.req_in_valid_i[cand]) begin
        grant_idx = IDX_W'(cand);
        grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (req_fire) begin
      rr_ptr_d = (int'(grant_idx) == NUM_CLUSTER - 1) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest valid index as winner.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NUM_CLUSTER - 1; k >= 0; k--) begin
      if (bus.req_in_valid_i[k]) begin
        grant_idx = IDX_W'(k);
        grant_any = 1'b1;
      end
    end
  end
`endif

  // The output register can take a beat when empty or when it drains now.
  assign stage_rdy = !rq_full_q || bus.req_out_ready_i;
  assign req_fire  = grant_any && stage_rdy;

  always_comb begin
    bus.req_in_ready_o = '0;
    if (req_fire) begin
      bus.req_in_ready_o[grant_idx] = 1'b1;
    end
  end

  assign sel_source = bus.req_in_source_i[int'(grant_idx)*SOURCE_BITS +: SOURCE_BITS];

  if (NUM_CLUSTER > 1) begin : g_tag
    assign tagged_source = {grant_idx, sel_source};
  end else begin : g_no_tag
    assign tagged_source = sel_source;
  end

  always_comb begin
    sel_beat.opcode  = bus.req_in_opcode_i[int'(grant_idx)*OP_BITS +: OP_BITS];
    sel_beat.size    = bus.req_in_size_i[int'(grant_idx)*SIZE_BITS +: SIZE_BITS];
    sel_beat.source  = tagged_source;
    sel_beat.address = bus.req_in_address_i[int'(grant_idx)*ADDRESS_BITS +: ADDRESS_BITS];
    sel_beat.mask    = bus.req_in_mask_i[int'(grant_idx)*MASK_BITS +: MASK_BITS];
    sel_beat.data    = bus.req_in_data_i[int'(grant_idx)*DATA_BITS +: DATA_BITS];
    sel_beat.param   = bus.req_in_param_i[int'(grant_idx)*PARAM_BITS +: PARAM_BITS];
  end

  always_comb begin
    rq_full_d = rq_full_q;
    rq_beat_d = rq_beat_q;
    if (req_fire) begin
      rq_full_d = 1'b1;
      rq_beat_d = sel_beat;
    end else if (bus.req_out_ready_i) begin
      rq_full_d = 1'b0;
    end
  end

  assign bus.req_out_valid_o   = rq_full_q;
  assign bus.req_out_opcode_o  = rq_beat_q.opcode;
  assign bus.req_out_size_o    = rq_beat_q.size;
  assign bus.req_out_source_o  = rq_beat_q.source;
  assign bus.req_out_address_o = rq_beat_q.address;
  assign bus.req_out_mask_o    = rq_beat_q.mask;
  assign bus.req_out_data_o    = rq_beat_q.data;
  assign bus.req_out_param_o   = rq_beat_q.param;

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]       rsp_tgt;
  logic                   rsp_tgt_ok;
  logic                   rsp_in_rdy;
  logic                   rsp_fire;
  rsp_beat_t              rsp_new;

  logic [NUM_CLUSTER-1:0] rs_full_q, rs_full_d;
  rsp_beat_t              rs_beat_q [NUM_CLUSTER];
  rsp_beat_t              rs_beat_d [NUM_CLUSTER];

  if (NUM_CLUSTER > 1) begin : g_tgt
    assign rsp_tgt = bus.rsp_in_source_i[SRC_OUT_W-1 -: ID_BITS];
  end else begin : g_no_tgt
    assign rsp_tgt = '0;
  end

  // Only reachable with a non-power-of-two cluster count.
  assign rsp_tgt_ok = int'(rsp_tgt) < NUM_CLUSTER;

  // Out-of-range targets are always accepted so the L2 never stalls on them.
  assign rsp_in_rdy         = !rsp_tgt_ok || !rs_full_q[rsp_tgt] || bus.rsp_out_ready_i[rsp_tgt];
  assign bus.rsp_in_ready_o = rsp_in_rdy;
  assign rsp_fire           = bus.rsp_in_valid_i && rsp_in_rdy;

  always_comb begin
    rsp_new.opcode  = bus.rsp_in_opcode_i;
    rsp_new.size    = bus.rsp_in_size_i;
    rsp_new.source  = bus.rsp_in_source_i[SOURCE_BITS-1:0];
    rsp_new.address = bus.rsp_in_address_i;
    rsp_new.data    = bus.rsp_in_data_i;
    rsp_new.param   = bus.rsp_in_param_i;
  end

  always_comb begin
    for (int k = 0; k < NUM_CLUSTER; k++) begin
      rs_full_d[k] = rs_full_q[k];
      rs_beat_d[k] = rs_beat_q[k];
      if (rs_full_q[k] && bus.rsp_out_ready_i[k]) begin
        rs_full_d[k] = 1'b0;
      end
      // Enqueue after dequeue: a same-cycle pair leaves the port full with
      // the new beat.
      if (rsp_fire && rsp_tgt_ok && (int'(rsp_tgt) == k)) begin
        rs_full_d[k] = 1'b1;
        rs_beat_d[k] = rsp_new;
      end
    end
  end

  assign bus.rsp_out_valid_o = rs_full_q;

  always_comb begin
    bus.rsp_out_opcode_o  = '0;
    bus.rsp_out_size_o    = '0;
    bus.rsp_out_source_o  = '0;
    bus.rsp_out_address_o = '0;
    bus.rsp_out_data_o    = '0;
    bus.rsp_out_param_o   = '0;
    for (int k = 0; k < NUM_CLUSTER; k++) begin
      bus.rsp_out_opcode_o[k*OP_BITS +: OP_BITS]             = rs_beat_q[k].opcode;
      bus.rsp_out_size_o[k*SIZE_BITS +: SIZE_BITS]           = rs_beat_q[k].size;
      bus.rsp_out_source_o[k*SOURCE_BITS +: SOURCE_BITS]     = rs_beat_q[k].source;
      bus.rsp_out_address_o[k*ADDRESS_BITS +: ADDRESS_BITS]  = rs_beat_q[k].address;
      bus.rsp_out_data_o[k*DATA_BITS +: DATA_BITS]           = rs_beat_q[k].data;
      bus.rsp_out_param_o[k*PARAM_BITS +: PARAM_BITS]        = rs_beat_q[k].param;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  // NOTE: the payload registers are reset as well as the valid flags, so the
  // outputs show a defined all-zero beat after reset rather than stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_full_q <= 1'b0;
      rq_beat_q <= '0;
      rs_full_q <= '0;
      for (int k = 0; k < NUM_CLUSTER; k++) begin
        rs_beat_q[k] <= '0;
      end
`ifdef CLUSTER_L2_ARB_RR_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      rq_full_q <= rq_full_d;
      rq_beat_q <= rq_beat_d;
      rs_full_q <= rs_full_d;
      for (int k = 0; k < NUM_CLUSTER; k++) begin
        rs_beat_q[k] <= rs_beat_d[k];
      end
`ifdef CLUSTER_L2_ARB_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_cluster_to_l2_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_cluster_to_l2_rr_arb
//
// Self-checking bench for cluster_to_l2_rr_arb with NUM_CLUSTER=4 and default
// field widths. Directed scenarios followed by a randomized run compared
// against a transaction-level reference model. The expected arbitration
// policy follows CLUSTER_L2_ARB_RR_EN in the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cluster_to_l2_rr_arb;
  localparam int N = 4;

  typedef struct packed {
    logic [2:0]   op;
    logic [2:0]   size;
    logic [9:0]   src;
    logic [31:0]  addr;
    logic [15:0]  mask;
    logic [127:0] data;
    logic [2:0]   param;
  } req_s;

  typedef struct packed {
    logic [2:0]   op;
    logic [2:0]   size;
    logic [9:0]   src;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [2:0]   param;
  } rsp_s;

  typedef struct packed {
    logic [2:0]   op;
    logic [2:0]   size;
    logic [7:0]   src;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [2:0]   param;
  } rsp_o_s;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  req_s req_cand [N];
  rsp_s rsp_cand;

  cluster_to_l2_rr_arb_if #(
    .NUM_CLUSTER(N), .OP_BITS(3), .SIZE_BITS(3), .SOURCE_BITS(8),
    .ADDRESS_BITS(32), .MASK_BITS(16), .DATA_BITS(128), .PARAM_BITS(3)
  ) bus ();

  cluster_to_l2_rr_arb #(
    .NUM_CLUSTER(N), .OP_BITS(3), .SIZE_BITS(3), .SOURCE_BITS(8),
    .ADDRESS_BITS(32), .MASK_BITS(16), .DATA_BITS(128), .PARAM_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_in_valid_i   = '0;
    bus.req_in_opcode_i  = '0;
    bus.req_in_size_i    = '0;
    bus.req_in_source_i  = '0;
    bus.req_in_address_i = '0;
    bus.req_in_mask_i    = '0;
    bus.req_in_data_i    = '0;
    bus.req_in_param_i   = '0;
    bus.req_out_ready_i  = 1'b0;
    bus.rsp_in_valid_i   = 1'b0;
    bus.rsp_in_opcode_i  = '0;
    bus.rsp_in_size_i    = '0;
    bus.rsp_in_source_i  = '0;
    bus.rsp_in_address_i = '0;
    bus.rsp_in_data_i    = '0;
    bus.rsp_in_param_i   = '0;
    bus.rsp_out_ready_i  = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_req(input int k);
    req_cand[k].op    = 3'($urandom);
    req_cand[k].size  = 3'($urandom);
    req_cand[k].src   = {2'b00, 8'($urandom)};
    req_cand[k].addr  = $urandom;
    req_cand[k].mask  = 16'($urandom);
    req_cand[k].data  = {$urandom, $urandom, $urandom, $urandom};
    req_cand[k].param = 3'($urandom);
  endtask

  task automatic rand_rsp();
    rsp_cand.op    = 3'($urandom);
    rsp_cand.size  = 3'($urandom);
    rsp_cand.src   = 10'($urandom);
    rsp_cand.addr  = $urandom;
    rsp_cand.data  = {$urandom, $urandom, $urandom, $urandom};
    rsp_cand.param = 3'($urandom);
  endtask

  task automatic drive_req();
    for (int k = 0; k < N; k++) begin
      bus.req_in_opcode_i[k*3 +: 3]    = req_cand[k].op;
      bus.req_in_size_i[k*3 +: 3]      = req_cand[k].size;
      bus.req_in_source_i[k*8 +: 8]    = req_cand[k].src[7:0];
      bus.req_in_address_i[k*32 +: 32] = req_cand[k].addr;
      bus.req_in_mask_i[k*16 +: 16]    = req_cand[k].mask;
      bus.req_in_data_i[k*128 +: 128]  = req_cand[k].data;
      bus.req_in_param_i[k*3 +: 3]     = req_cand[k].param;
    end
  endtask

  task automatic drive_rsp();
    bus.rsp_in_opcode_i  = rsp_cand.op;
    bus.rsp_in_size_i    = rsp_cand.size;
    bus.rsp_in_source_i  = rsp_cand.src;
    bus.rsp_in_address_i = rsp_cand.addr;
    bus.rsp_in_data_i    = rsp_cand.data;
    bus.rsp_in_param_i   = rsp_cand.param;
  endtask

  function automatic req_s obs_req();
    return {bus.req_out_opcode_o, bus.req_out_size_o, bus.req_out_source_o,
            bus.req_out_address_o, bus.req_out_mask_o, bus.req_out_data_o,
            bus.req_out_param_o};
  endfunction

  function automatic req_s tag_req(input req_s c, input int k);
    req_s r = c;
    r.src = {2'(k), c.src[7:0]};
    return r;
  endfunction

  function automatic rsp_o_s obs_rsp(input int k);
    return {bus.rsp_out_opcode_o[k*3 +: 3], bus.rsp_out_size_o[k*3 +: 3],
            bus.rsp_out_source_o[k*8 +: 8], bus.rsp_out_address_o[k*32 +: 32],
            bus.rsp_out_data_o[k*128 +: 128], bus.rsp_out_param_o[k*3 +: 3]};
  endfunction

  function automatic rsp_o_s exp_rsp(input rsp_s r);
    return {r.op, r.size, r.src[7:0], r.addr, r.data, r.param};
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus.req_out_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid got %b want 0", bus.req_out_valid_o);
    end
    checks++;
    if (bus.rsp_out_valid_o !== 4'b0000) begin
      errors++; $display("FAIL reset_rsp_valid got %b want 0000", bus.rsp_out_valid_o);
    end
    checks++;
    if (obs_req() !== req_s'(0)) begin
      errors++; $display("FAIL reset_req_payload got %h want 0", obs_req());
    end
    checks++;
    if (bus.rsp_out_data_o !== '0) begin
      errors++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_out_data_o);
    end
    checks++;
    if (bus.req_in_ready_o !== 4'b0000 || bus.rsp_in_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_readies got req %b rsp %b want 0000 1",
                         bus.req_in_ready_o, bus.rsp_in_ready_o);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    apply_reset();
    for (int k = 0; k < N; k++) rand_req(k);
    drive_req();
    bus.req_out_ready_i = 1'b1;
`ifdef CLUSTER_L2_ARB_RR_EN
    bus.req_in_valid_i = 4'b1111;
`else
    bus.req_in_valid_i = 4'b1010;
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef CLUSTER_L2_ARB_RR_EN
      exp_rdy = 4'(1 << (i % N));
      exp_id  = 2'((i + N - 1) % N);
`else
      exp_rdy = 4'b0010;
      exp_id  = 2'd1;
`endif
      checks++;
      if (bus.req_in_ready_o !== exp_rdy) begin
        errors++; $display("FAIL arb_grant cycle %0d got %b want %b", i, bus.req_in_ready_o, exp_rdy);
      end
      if (i > 0) begin
        checks++;
        if (bus.req_out_valid_o !== 1'b1 || bus.req_out_source_o[9:8] !== exp_id) begin
          errors++; $display("FAIL arb_out_id cycle %0d got valid %b id %0d want 1 %0d",
                             i, bus.req_out_valid_o, bus.req_out_source_o[9:8], exp_id);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    req_s first_beat;
    req_s second_beat;
    apply_reset();
    rand_req(2);
    req_cand[2].src = 10'h05A;
    drive_req();
    bus.req_in_valid_i  = 4'b0100;
    bus.req_out_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_in_ready_o !== 4'b0100 || bus.req_out_valid_o !== 1'b0) begin
      errors++; $display("FAIL hold_accept got rdy %b valid %b want 0100 0",
                         bus.req_in_ready_o, bus.req_out_valid_o);
    end
    first_beat = tag_req(req_cand[2], 2);
    tick();
    // New beat presented on the same port must not disturb the held one.
    rand_req(2);
    req_cand[2].src = 10'h077;
    drive_req();
    second_beat = tag_req(req_cand[2], 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.req_in_ready_o !== 4'b0000) begin
        errors++; $display("FAIL hold_ready cycle %0d got %b want 0000", i, bus.req_in_ready_o);
      end
      checks++;
      if (bus.req_out_valid_o !== 1'b1 || bus.req_out_source_o !== 10'h25A || obs_req() !== first_beat) begin
        errors++; $display("FAIL hold_payload cycle %0d got %b %h want 1 %h",
                           i, bus.req_out_valid_o, obs_req(), first_beat);
      end
      tick();
    end
    bus.req_out_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_in_ready_o !== 4'b0100 || obs_req() !== first_beat) begin
      errors++; $display("FAIL hold_release got rdy %b beat %h want 0100 %h",
                         bus.req_in_ready_o, obs_req(), first_beat);
    end
    tick();
    bus.req_in_valid_i = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus.req_out_valid_o !== 1'b1 || obs_req() !== second_beat) begin
      errors++; $display("FAIL hold_second got %b %h want 1 %h", bus.req_out_valid_o, obs_req(), second_beat);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.req_out_valid_o !== 1'b0) begin
      errors++; $display("FAIL hold_drain got %b want 0", bus.req_out_valid_o);
    end
  endtask

  task automatic test_response_route();
    rsp_s r1;
    rsp_s r2;
    apply_reset();
    bus.rsp_out_ready_i = 4'b1111;
    rand_rsp();
    rsp_cand.src = 10'h111;
    r1 = rsp_cand;
    drive_rsp();
    bus.rsp_in_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rsp_in_ready_o !== 1'b1) begin
      errors++; $display("FAIL route_ready1 got %b want 1", bus.rsp_in_ready_o);
    end
    tick();
    rand_rsp();
    rsp_cand.src = 10'h322;
    r2 = rsp_cand;
    drive_rsp();
    @(negedge clk);
    checks++;
    if (bus.rsp_out_valid_o !== 4'b0010 || obs_rsp(1) !== exp_rsp(r1)) begin
      errors++; $display("FAIL route_port1 got %b %h want 0010 %h", bus.rsp_out_valid_o, obs_rsp(1), exp_rsp(r1));
    end
    tick();
    bus.rsp_in_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_out_valid_o !== 4'b1000 || bus.rsp_out_source_o[31:24] !== 8'h22 || obs_rsp(3) !== exp_rsp(r2)) begin
      errors++; $display("FAIL route_port3 got %b %h want 1000 %h", bus.rsp_out_valid_o, obs_rsp(3), exp_rsp(r2));
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.rsp_out_valid_o !== 4'b0000) begin
      errors++; $display("FAIL route_drain got %b want 0000", bus.rsp_out_valid_o);
    end
  endtask

  task automatic test_backpressure();
    rsp_s r1;
    rsp_s r3;
    rsp_s r4;
    apply_reset();
    rand_rsp();
    rsp_cand.src = 10'h133;
    r1 = rsp_cand;
    drive_rsp();
    bus.rsp_in_valid_i = 1'b1;
    tick();
    rand_rsp();
    rsp_cand.src = 10'h144;
    drive_rsp();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_in_ready_o !== 1'b0 || obs_rsp(1) !== exp_rsp(r1)) begin
        errors++; $display("FAIL bp_stall cycle %0d got rdy %b beat %h want 0 %h",
                           i, bus.rsp_in_ready_o, obs_rsp(1), exp_rsp(r1));
      end
      tick();
    end
    rand_rsp();
    rsp_cand.src = 10'h355;
    r3 = rsp_cand;
    drive_rsp();
    @(negedge clk);
    checks++;
    if (bus.rsp_in_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_other_port got %b want 1", bus.rsp_in_ready_o);
    end
    tick();
    bus.rsp_in_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_out_valid_o !== 4'b1010 || obs_rsp(3) !== exp_rsp(r3) || obs_rsp(1) !== exp_rsp(r1)) begin
      errors++; $display("FAIL bp_both_held got %b p1 %h p3 %h", bus.rsp_out_valid_o, obs_rsp(1), obs_rsp(3));
    end
    tick();
    // Enqueue and dequeue on port 1 in the same cycle.
    rand_rsp();
    rsp_cand.src = 10'h166;
    r4 = rsp_cand;
    drive_rsp();
    bus.rsp_in_valid_i  = 1'b1;
    bus.rsp_out_ready_i = 4'b0010;
    @(negedge clk);
    checks++;
    if (bus.rsp_in_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_pass_ready got %b want 1", bus.rsp_in_ready_o);
    end
    tick();
    bus.rsp_in_valid_i  = 1'b0;
    bus.rsp_out_ready_i = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus.rsp_out_valid_o !== 4'b1010 || obs_rsp(1) !== exp_rsp(r4)) begin
      errors++; $display("FAIL bp_pass_beat got %b %h want 1010 %h", bus.rsp_out_valid_o, obs_rsp(1), exp_rsp(r4));
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < N; k++) rand_req(k);
    drive_req();
    bus.req_in_valid_i = 4'b1000;
    rand_rsp();
    rsp_cand.src = 10'h2AB;
    drive_rsp();
    bus.rsp_in_valid_i = 1'b1;
    tick();
    bus.req_in_valid_i = 4'b0000;
    bus.rsp_in_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_out_valid_o !== 1'b1 || bus.rsp_out_valid_o !== 4'b0100) begin
      errors++; $display("FAIL rmid_loaded got %b %b want 1 0100", bus.req_out_valid_o, bus.rsp_out_valid_o);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_out_valid_o !== 1'b0 || bus.rsp_out_valid_o !== 4'b0000) begin
      errors++; $display("FAIL rmid_async got %b %b want 0 0000", bus.req_out_valid_o, bus.rsp_out_valid_o);
    end
    tick();
    rst = 1'b0;
    bus.req_in_valid_i  = 4'b1111;
    bus.req_out_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_in_ready_o !== 4'b0001 || bus.req_out_valid_o !== 1'b0) begin
      errors++; $display("FAIL rmid_first_grant got %b %b want 0001 0", bus.req_in_ready_o, bus.req_out_valid_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.req_out_valid_o !== 1'b1 || bus.req_out_source_o[9:8] !== 2'd0) begin
      errors++; $display("FAIL rmid_first_id got %b %0d want 1 0", bus.req_out_valid_o, bus.req_out_source_o[9:8]);
    end
  endtask

  // Transaction-level model: a one-deep slot toward L2 and one slot per
  // cluster, updated from the handshakes the rules say must happen.
  task automatic test_random();
    bit         m_full;
    req_s       m_beat;
    bit   [3:0] m_rs_full;
    rsp_o_s     m_rs [N];
    int         win;
    int         t;
    logic [3:0] exp_rdy;
    logic       exp_in_rdy;
`ifdef CLUSTER_L2_ARB_RR_EN
    int         m_ptr;
    m_ptr = 0;
`endif
    apply_reset();
    m_full    = 1'b0;
    m_beat    = '0;
    m_rs_full = '0;
    for (int k = 0; k < N; k++) m_rs[k] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < N; k++) rand_req(k);
      drive_req();
      bus.req_in_valid_i  = 4'($urandom);
      bus.req_out_ready_i = ($urandom % 4) != 0;
      rand_rsp();
      drive_rsp();
      bus.rsp_in_valid_i  = 1'($urandom);
      bus.rsp_out_ready_i = 4'($urandom);
      @(negedge clk);

      win = -1;
`ifdef CLUSTER_L2_ARB_RR_EN
      for (int off = 0; off < N; off++) begin
        if (win < 0 && bus.req_in_valid_i[(m_ptr + off) % N]) win = (m_ptr + off) % N;
      end
`else
      for (int k = 0; k < N; k++) begin
        if (win < 0 && bus.req_in_valid_i[k]) win = k;
      end
`endif
      exp_rdy = (win >= 0 && (!m_full || bus.req_out_ready_i)) ? 4'(1 << win) : 4'b0000;
      checks++;
      if (bus.req_in_ready_o !== exp_rdy) begin
        errors++; $display("FAIL rand_req_ready cyc %0d got %b want %b", cyc, bus.req_in_ready_o, exp_rdy);
      end
      checks++;
      if (bus.req_out_valid_o !== m_full) begin
        errors++; $display("FAIL rand_req_valid cyc %0d got %b want %b", cyc, bus.req_out_valid_o, m_full);
      end
      if (m_full) begin
        checks++;
        if (obs_req() !== m_beat) begin
          errors++; $display("FAIL rand_req_beat cyc %0d got %h want %h", cyc, obs_req(), m_beat);
        end
      end

      t = int'(rsp_cand.src[9:8]);
      exp_in_rdy = !m_rs_full[t] || bus.rsp_out_ready_i[t];
      checks++;
      if (bus.rsp_in_ready_o !== exp_in_rdy) begin
        errors++; $display("FAIL rand_rsp_ready cyc %0d got %b want %b", cyc, bus.rsp_in_ready_o, exp_in_rdy);
      end
      checks++;
      if (bus.rsp_out_valid_o !== m_rs_full) begin
        errors++; $display("FAIL rand_rsp_valid cyc %0d got %b want %b", cyc, bus.rsp_out_valid_o, m_rs_full);
      end
      for (int k = 0; k < N; k++) begin
        if (m_rs_full[k]) begin
          checks++;
          if (obs_rsp(k) !== m_rs[k]) begin
            errors++; $display("FAIL rand_rsp_beat cyc %0d port %0d got %h want %h", cyc, k, obs_rsp(k), m_rs[k]);
          end
        end
      end

      if (exp_rdy != 4'b0000) begin
        m_full = 1'b1;
        m_beat = tag_req(req_cand[win], win);
`ifdef CLUSTER_L2_ARB_RR_EN
        m_ptr  = (win + 1) % N;
`endif
      end else if (bus.req_out_ready_i) begin
        m_full = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        if (m_rs_full[k] && bus.rsp_out_ready_i[k]) m_rs_full[k] = 1'b0;
      end
      if (bus.rsp_in_valid_i && exp_in_rdy) begin
        m_rs_full[t] = 1'b1;
        m_rs[t]      = exp_rsp(rsp_cand);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_hold();
    test_response_route();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
